// File: rtl/i2s_tdm_ws_gen_if.sv
// Configuration and frame-position bundle between the I2S uDMA master
// control logic (master side) and the TDM/DSP frame-sync generator (slave side).
interface i2s_tdm_ws_gen_if #(
    parameter int MAX_BITS  = 32,
    parameter int MAX_SLOTS = 16,
    parameter int SETUP_W   = 16
);
    localparam int BW = $clog2(MAX_BITS);
    localparam int SW = $clog2(MAX_SLOTS);

    // Configuration, driven by the control side.
    logic               cfg_en_i;
    logic [BW-1:0]      cfg_num_bits_i;
    logic [SW-1:0]      cfg_num_slots_i;
    logic [SETUP_W-1:0] cfg_setup_time_i;
    logic [1:0]         cfg_pulse_mode_i;
    logic               cfg_lead_i;
    logic               cfg_ws_pol_i;

    // Frame sync and position strobes, driven by the generator.
    logic               ws_o;
    logic               frame_start_o;
    logic               slot_start_o;
    logic [SW-1:0]      slot_o;
    logic [BW-1:0]      bit_o;
    logic               busy_o;

    modport master (
        output cfg_en_i, cfg_num_bits_i, cfg_num_slots_i, cfg_setup_time_i,
               cfg_pulse_mode_i, cfg_lead_i, cfg_ws_pol_i,
        input  ws_o, frame_start_o, slot_start_o, slot_o, bit_o, busy_o
    );

    modport slave (
        input  cfg_en_i, cfg_num_bits_i, cfg_num_slots_i, cfg_setup_time_i,
               cfg_pulse_mode_i, cfg_lead_i, cfg_ws_pol_i,
        output ws_o, frame_start_o, slot_start_o, slot_o, bit_o, busy_o
    );
endinterface

// File: rtl/i2s_tdm_ws_gen.sv
// TDM/DSP frame-sync generator for the uDMA I2S master path. Produces a
// programmable frame sync (pulse shape, one-bit lead, polarity, setup delay)
// plus slot/bit position strobes for the serializer and deserializer.
// Outputs are registered from the current state, so they trail it by one cycle.
module i2s_tdm_ws_gen #(
    parameter int MAX_BITS  = 32,
    parameter int MAX_SLOTS = 16,
    parameter int SETUP_W   = 16
) (
    input  logic            sck_i,
    input  logic            rst_i,
    i2s_tdm_ws_gen_if.slave bus
);
    localparam int BW = $clog2(MAX_BITS);
    localparam int SW = $clog2(MAX_SLOTS);
    localparam int PW = BW + SW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Frame configuration held stable for a whole frame.
    typedef struct packed {
        logic [BW-1:0] num_bits;
        logic [SW-1:0] num_slots;
        logic [1:0]    mode;
        logic          lead;
        logic          pol;
    } shadow_t;

    state_t             state_q, state_d;
    shadow_t            shd_q, shd_d, live_cfg;
    logic [BW-1:0]      bit_q, bit_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;

    logic               last_bit, last_slot, frame_end;
    logic [PW:0]        frame_len;
    logic [PW-1:0]      half_len, win_len;
    logic               run_active;

    logic               ws_d, frame_start_d, slot_start_d, busy_d;
    logic [SW-1:0]      slot_out_d;
    logic [BW-1:0]      bit_out_d;
    logic               ws_q, frame_start_q, slot_start_q, busy_q;
    logic [SW-1:0]      slot_out_q;
    logic [BW-1:0]      bit_out_q;

    assign live_cfg  = {bus.cfg_num_bits_i, bus.cfg_num_slots_i,
                        bus.cfg_pulse_mode_i, bus.cfg_lead_i, bus.cfg_ws_pol_i};
    assign last_bit  = (bit_q == shd_q.num_bits);
    assign last_slot = (slot_q == shd_q.num_slots);
    assign frame_end = last_bit && last_slot;

    // Active-window length of the frame sync for the shadowed pulse mode.
    always_comb begin
        // The full frame length needs one bit more than a position (32*16 = 512).
        frame_len = ((PW+1)'(shd_q.num_bits) + (PW+1)'(1)) *
                    ((PW+1)'(shd_q.num_slots) + (PW+1)'(1));
        half_len  = PW'(frame_len >> 1);
        case (shd_q.mode)
            2'b01:   win_len = PW'(shd_q.num_bits) + PW'(1);
            2'b10:   win_len = (half_len == '0) ? PW'(1) : half_len;
            default: win_len = PW'(1);
        endcase
    end

    // Next-state, counter, shadow-reload and next-output logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        shd_d         = shd_q;
        bit_d         = bit_q;
        slot_d        = slot_q;
        pos_d         = pos_q;
        setup_cnt_d   = setup_cnt_q;
        run_active    = 1'b0;
        ws_d          = bus.cfg_ws_pol_i;
        frame_start_d = 1'b0;
        slot_start_d  = 1'b0;
        slot_out_d    = '0;
        bit_out_d     = '0;
        busy_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_d       = '0;
                slot_d      = '0;
                pos_d       = '0;
                setup_cnt_d = '0;
                if (bus.cfg_en_i) begin
                    shd_d = live_cfg;
                    if (bus.cfg_setup_time_i != '0) begin
                        state_d     = ST_SETUP;
                        setup_cnt_d = bus.cfg_setup_time_i;
                    end else if (bus.cfg_lead_i) begin
                        // Lead mode needs at least one cycle to place the lead pulse.
                        state_d     = ST_SETUP;
                        setup_cnt_d = SETUP_W'(1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_SETUP: begin
                busy_d = 1'b1;
                ws_d   = (shd_q.lead && setup_cnt_q == SETUP_W'(1)) ? ~shd_q.pol : shd_q.pol;
                if (!bus.cfg_en_i) begin
                    state_d     = ST_IDLE;
                    setup_cnt_d = '0;
                end else if (setup_cnt_q == SETUP_W'(1)) begin
                    state_d     = ST_RUN;
                    setup_cnt_d = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q - SETUP_W'(1);
                end
            end

            ST_RUN: begin
                busy_d        = 1'b1;
                frame_start_d = (bit_q == '0) && (slot_q == '0);
                slot_start_d  = (bit_q == '0);
                slot_out_d    = slot_q;
                bit_out_d     = bit_q;

                if (frame_end) begin
                    // The lead pulse belongs to the coming frame, so it follows
                    // the configuration that is reloaded on this cycle.
                    if (bus.cfg_lead_i) ws_d = ~bus.cfg_ws_pol_i;
                    else                ws_d = (pos_q < win_len) ^ shd_q.pol;
                end else begin
                    if (shd_q.lead) run_active = (pos_q + PW'(1)) < win_len;
                    else            run_active = pos_q < win_len;
                    ws_d = run_active ^ shd_q.pol;
                end

                if (!bus.cfg_en_i) begin
                    state_d = ST_IDLE;
                    bit_d   = '0;
                    slot_d  = '0;
                    pos_d   = '0;
                end else if (last_bit) begin
                    bit_d = '0;
                    if (last_slot) begin
                        slot_d = '0;
                        pos_d  = '0;
                        shd_d  = live_cfg;
                    end else begin
                        slot_d = slot_q + SW'(1);
                        pos_d  = pos_q + PW'(1);
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                    pos_d = pos_q + PW'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and shadow configuration advance on every bit clock.
    always_ff @(posedge sck_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shd_q       <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            pos_q       <= '0;
            setup_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shd_q       <= shd_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            pos_q       <= pos_d;
            setup_cnt_q <= setup_cnt_d;
        end
    end

    // Output registers keep the sync and strobes glitch-free at the pins.
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            slot_start_q  <= 1'b0;
            slot_out_q    <= '0;
            bit_out_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            slot_start_q  <= slot_start_d;
            slot_out_q    <= slot_out_d;
            bit_out_q     <= bit_out_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.ws_o          = ws_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.slot_start_o  = slot_start_q;
    assign bus.slot_o        = slot_out_q;
    assign bus.bit_o         = bit_out_q;
    assign bus.busy_o        = busy_q;
endmodule
